clock_supervisor: RTL and testbench

// - Parametrised lock supervisor and reset sequencer for DCM/PLL-based clock services; successor to the single-domain FDR reset scheme.
// - Pulses the DCM reset, waits for lock with a timeout and retry, requires lock to be stable before releasing anything.
// - Releases NCHAN active-low resets in staggered order; on unlock, re-asserts all of them and restarts the sequence.
// - Runs entirely on the reference clock; each consumer synchronises its rstnOut bit into its own domain.

---
 rtl/clock_supervisor_pkg.sv | 19 +
 rtl/clock_supervisor_sync_bit.sv | 24 ++
 rtl/clock_supervisor.sv | 155 +++++++++++++++
 tb/tb_clock_supervisor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_supervisor_pkg.sv
// Shared types for the clock supervisor: FSM state encoding, status count width
// and the saturating increment used by the lock-loss and retry counters.
package clock_supervisor_pkg;

    localparam int unsigned COUNT_W = 8;

    typedef enum logic [2:0] {
        CS_RESET_DCM = 3'd0,
        CS_WAIT_LOCK = 3'd1,
        CS_STABLE    = 3'd2,
        CS_RELEASE   = 3'd3,
        CS_RUN       = 3'd4
    } cs_state_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/clock_supervisor_sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-low clear.
// Reusable by consumer domains to bring a reset/status bit into their clock.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/clock_supervisor.sv
// DCM/PLL lock supervisor: pulses the DCM reset, waits for a stable lock with
// timeout/retry, then releases NCHAN active-low resets in staggered order.
module clock_supervisor
    import clock_supervisor_pkg::*;
#(
    parameter int unsigned NCHAN        = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned RST_PULSE    = 8,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned STABLE_CYC   = 256,
    parameter int unsigned STAGGER      = 16,
    parameter int unsigned CNTW         = 20
) (
    input  logic               clkIn,
    input  logic               rstIn,
    input  logic               locked,
    input  logic               softRst,
    output logic               rstDCM,
    output logic [NCHAN-1:0]   rstnOut,
    output logic               allReady,
    output logic [COUNT_W-1:0] unlockCount,
    output logic [COUNT_W-1:0] retryCount,
    output logic [2:0]         state
);

    localparam int unsigned CHW = $clog2(NCHAN) + 1;

    logic               locked_s;
    cs_state_t          st, st_n;
    logic [CNTW-1:0]    cnt, cnt_n;
    logic [CHW-1:0]     chan, chan_n;
    logic               rstdcm_n, ready_n;
    logic [NCHAN-1:0]   rstn_n;
    logic [COUNT_W-1:0] unl_n, rty_n;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clkIn),
        .rst_n (rstIn),
        .d     (locked),
        .q     (locked_s)
    );

    always_comb begin
        st_n   = st;
        cnt_n  = cnt + CNTW'(1);
        chan_n = chan;
        rstn_n = rstnOut;
        ready_n = allReady;
        unl_n  = unlockCount;
        rty_n  = retryCount;

        // softRst outranks every state action, including unlock accounting
        if (softRst) begin
            st_n    = CS_RESET_DCM;
            cnt_n   = '0;
            rstn_n  = '0;
            ready_n = 1'b0;
        end else begin
            case (st)
                CS_RESET_DCM: begin
                    if (cnt == CNTW'(RST_PULSE - 1)) begin
                        st_n  = CS_WAIT_LOCK;
                        cnt_n = '0;
                    end
                end
                CS_WAIT_LOCK: begin
                    if (locked_s) begin
                        st_n  = CS_STABLE;
                        cnt_n = '0;
                    end else if (cnt == CNTW'(LOCK_TIMEOUT - 1)) begin
                        st_n  = CS_RESET_DCM;
                        cnt_n = '0;
                        rty_n = sat_inc(retryCount);
                    end
                end
                CS_STABLE: begin
                    if (!locked_s) begin
                        st_n  = CS_WAIT_LOCK;
                        cnt_n = '0;
                    end else if (cnt == CNTW'(STABLE_CYC - 1)) begin
                        cnt_n  = '0;
                        chan_n = '0;
                        rstn_n = NCHAN'(1);
                        if (NCHAN == 1) begin
                            st_n    = CS_RUN;
                            ready_n = 1'b1;
                        end else begin
                            st_n = CS_RELEASE;
                        end
                    end
                end
                CS_RELEASE: begin
                    if (!locked_s) begin
                        st_n    = CS_RESET_DCM;
                        cnt_n   = '0;
                        rstn_n  = '0;
                        ready_n = 1'b0;
                        unl_n   = sat_inc(unlockCount);
                    end else if (cnt == CNTW'(STAGGER - 1)) begin
                        cnt_n  = '0;
                        chan_n = chan + CHW'(1);
                        rstn_n = (rstnOut << 1) | NCHAN'(1);
                        if (chan_n == CHW'(NCHAN - 1)) begin
                            st_n    = CS_RUN;
                            ready_n = 1'b1;
                        end
                    end
                end
                CS_RUN: begin
                    cnt_n = cnt;
                    if (!locked_s) begin
                        st_n    = CS_RESET_DCM;
                        cnt_n   = '0;
                        rstn_n  = '0;
                        ready_n = 1'b0;
                        unl_n   = sat_inc(unlockCount);
                    end
                end
                default: begin
                    st_n    = CS_RESET_DCM;
                    cnt_n   = '0;
                    rstn_n  = '0;
                    ready_n = 1'b0;
                end
            endcase
        end

        rstdcm_n = (st_n == CS_RESET_DCM);
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            st          <= CS_RESET_DCM;
            cnt         <= '0;
            chan        <= '0;
            rstDCM      <= 1'b1;
            rstnOut     <= '0;
            allReady    <= 1'b0;
            unlockCount <= '0;
            retryCount  <= '0;
        end else begin
            st          <= st_n;
            cnt         <= cnt_n;
            chan        <= chan_n;
            rstDCM      <= rstdcm_n;
            rstnOut     <= rstn_n;
            allReady    <= ready_n;
            unlockCount <= unl_n;
            retryCount  <= rty_n;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_clock_supervisor.sv
// Randomised scoreboard bench for clock_supervisor with a phase/elapsed-time
// reference model; a monitor compares every clock edge and async reset.
module tb_clock_supervisor;

    localparam int NCHAN = 3;
    localparam int SYNC  = 2;
    localparam int RP    = 4;
    localparam int TO    = 32;
    localparam int SC    = 8;
    localparam int STG   = 2;

    localparam int P_PULSE  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_REL    = 3;
    localparam int P_RUN    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             locked;
    logic             softRst;
    logic             rstDCM;
    logic [NCHAN-1:0] rstnOut;
    logic             allReady;
    logic [7:0]       unlockCount;
    logic [7:0]       retryCount;
    logic [2:0]       state;

    clock_supervisor #(
        .NCHAN(NCHAN), .SYNC_STAGES(SYNC), .RST_PULSE(RP), .LOCK_TIMEOUT(TO),
        .STABLE_CYC(SC), .STAGGER(STG), .CNTW(8)
    ) dut (
        .clkIn(clk), .rstIn(rst_n), .locked(locked), .softRst(softRst),
        .rstDCM(rstDCM), .rstnOut(rstnOut), .allReady(allReady),
        .unlockCount(unlockCount), .retryCount(retryCount), .state(state)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic             dcm;
        logic [NCHAN-1:0] rstn;
        logic             rdy;
        logic [7:0]       unl;
        logic [7:0]       rty;
        logic [2:0]       st;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: phase, edge index of phase entry, synchroniser history
    int m_ph, m_entered, m_cyc, m_unl, m_rty;
    bit m_pipe[$];

    function automatic void model_reset();
        m_ph = P_PULSE;
        m_entered = m_cyc;
        m_unl = 0;
        m_rty = 0;
        m_pipe = {};
        for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
    endfunction

    function automatic void go(int p);
        m_ph = p;
        m_entered = m_cyc;
    endfunction

    function automatic void model_edge();
        bit ls;
        int d;
        m_cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls = m_pipe[SYNC-1];
        m_pipe.push_front(locked);
        void'(m_pipe.pop_back());
        d = m_cyc - m_entered;
        if (softRst) begin
            go(P_PULSE);
        end else begin
            case (m_ph)
                P_PULSE:  if (d == RP) go(P_WAIT);
                P_WAIT: begin
                    if (ls) go(P_STABLE);
                    else if (d == TO) begin
                        go(P_PULSE);
                        if (m_rty < 255) m_rty++;
                    end
                end
                P_STABLE: begin
                    if (!ls) go(P_WAIT);
                    else if (d == SC) go(P_REL);
                end
                default: begin
                    if (!ls) begin
                        go(P_PULSE);
                        if (m_unl < 255) m_unl++;
                    end else if (m_ph == P_REL && 1 + d / STG >= NCHAN) begin
                        go(P_RUN);
                    end
                end
            endcase
        end
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        int n;
        n = 0;
        if (m_ph == P_RUN) n = NCHAN;
        else if (m_ph == P_REL) n = 1 + (m_cyc - m_entered) / STG;
        e.dcm  = (m_ph == P_PULSE);
        e.rstn = NCHAN'((1 << n) - 1);
        e.rdy  = (m_ph == P_RUN);
        e.unl  = 8'(m_unl);
        e.rty  = 8'(m_rty);
        e.st   = 3'(m_ph);
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // monitor: every clock edge or async reset assertion consumes one entry
    initial begin
        exp_t e;
        #3;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = sb.pop_front();
                cmp("rstDCM", 32'(rstDCM), 32'(e.dcm));
                cmp("rstnOut", 32'(rstnOut), 32'(e.rstn));
                cmp("allReady", 32'(allReady), 32'(e.rdy));
                cmp("unlockCount", 32'(unlockCount), 32'(e.unl));
                cmp("retryCount", 32'(retryCount), 32'(e.rty));
                cmp("state", 32'(state), 32'(e.st));
            end
        end
    end

    initial begin
        int   hold;
        int   regime;
        int   asyncs;
        int   soft_at;
        bit   prev_locked;
        exp_t cur;

        hold = 3; regime = 0; asyncs = 0; soft_at = -1;
        m_cyc = 0;
        rst_n = 1'b0;
        locked = 1'b0;
        softRst = 1'b0;
        model_reset();
        model_edge();
        sb.push_back(snapshot());

        for (int c = 0; c < 26000; c++) begin
            @(negedge clk);
            #2;
            cur = snapshot();
            if (!rst_n) begin
                if (hold > 0) hold--;
                else rst_n = 1'b1;
            end else if (c < 6000 && asyncs < 6 &&
                         ((cur.rstn == 3'b001 && $urandom_range(0, 1) == 0) ||
                          $urandom_range(0, 699) == 0)) begin
                rst_n = 1'b0;
                hold = $urandom_range(0, 2);
                asyncs++;
                model_reset();
                sb.push_back(snapshot());
            end

            prev_locked = locked;
            if (c < 6000) begin
                if (c % 80 == 0) regime = $urandom_range(0, 3);
                case (regime)
                    0: locked = 1'b1;
                    1: locked = 1'b0;
                    2: if ($urandom_range(0, 7) == 0) locked = ~locked;
                    default: locked = ($urandom_range(0, 39) != 0);
                endcase
                softRst = ($urandom_range(0, 149) == 0);
                // line softRst up with the edge where the dropped lock reaches the FSM
                if (prev_locked && !locked && m_ph == P_RUN && $urandom_range(0, 1) == 0)
                    soft_at = c + SYNC;
                if (c == soft_at) softRst = 1'b1;
            end else if (c < 16000) begin
                locked = 1'b0;
                softRst = 1'b0;
            end else begin
                locked = (c % 32 != 0);
                softRst = 1'b0;
            end

            model_edge();
            sb.push_back(snapshot());
        end

        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
